// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings and the issue-controller state enum.
// Used by the issue controller, the execution units and the final result mux.
package fpu_pkg;

    localparam logic [2:0] OPC_ADD  = 3'd0;
    localparam logic [2:0] OPC_SUB  = 3'd1;
    localparam logic [2:0] OPC_MUL  = 3'd2;
    localparam logic [2:0] OPC_DIV  = 3'd3;
    localparam logic [2:0] OPC_CMP  = 3'd4;
    localparam logic [2:0] OPC_IDLE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } fsm_state_t;

    function automatic logic opc_is_legal(input logic [2:0] opc);
        return opc <= OPC_CMP;
    endfunction

endpackage

// File: rtl/fpu_lat_timer.sv
// Loadable down-counter with a zero flag; serves both the fixed-latency wait
// and the divider timeout (loaded with the timeout and counted down).
module fpu_lat_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FPU issue controller: registers one request onto the unit
// bus, waits fixed latency or divider completion, and holds the response.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int ADD_LAT     = 2,
    parameter int MUL_LAT     = 3,
    parameter int CMP_LAT     = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_opc,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [2:0]  opc_out,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] res_data,
    input  logic        res_aeb,
    input  logic        res_agb,
    input  logic        res_alb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_aeb,
    output logic        rsp_agb,
    output logic        rsp_alb,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int MAX_A    = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_B    = (CMP_LAT > DIV_TIMEOUT) ? CMP_LAT : DIV_TIMEOUT;
    localparam int MAX_LOAD = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW       = $clog2(MAX_LOAD + 1);

    localparam logic [TW-1:0] ADD_LOAD = TW'(ADD_LAT - 1);
    localparam logic [TW-1:0] MUL_LOAD = TW'(MUL_LAT - 1);
    localparam logic [TW-1:0] CMP_LOAD = TW'(CMP_LAT - 1);
    localparam logic [TW-1:0] DIV_LOAD = TW'(DIV_TIMEOUT);

    fsm_state_t    r_state, w_state_nxt;
    logic [31:0]   r_op_a, r_op_b, r_rsp_data;
    logic [2:0]    r_opc_out;
    logic          r_div_start;
    logic          r_rsp_aeb, r_rsp_agb, r_rsp_alb, r_rsp_err;
    logic          w_accept, w_capture, w_err_rsp, w_handshake;
    logic          w_load, w_dec, w_zero;
    logic [TW-1:0] w_load_val;

    fpu_lat_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_handshake = (r_state == ST_RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_err_rsp   = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_load = 1'b1;
                    case (req_opc)
                        OPC_ADD, OPC_SUB: begin
                            w_load_val  = ADD_LOAD;
                            w_state_nxt = ST_EXEC;
                        end
                        OPC_MUL: begin
                            w_load_val  = MUL_LOAD;
                            w_state_nxt = ST_EXEC;
                        end
                        OPC_CMP: begin
                            w_load_val  = CMP_LOAD;
                            w_state_nxt = ST_EXEC;
                        end
                        OPC_DIV: begin
                            w_load_val  = DIV_LOAD;
                            w_state_nxt = ST_DIV_WAIT;
                        end
                        default: begin
                            w_err_rsp   = 1'b1;
                            w_state_nxt = ST_RESP;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_DIV_WAIT: begin
                w_dec = 1'b1;
                // A done coincident with our own start pulse cannot be for this op.
                if (div_done && !r_div_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_zero) begin
                    w_err_rsp   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_opc_out   <= OPC_IDLE;
            r_div_start <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_aeb   <= 1'b0;
            r_rsp_agb   <= 1'b0;
            r_rsp_alb   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_div_start <= w_accept && (req_opc == OPC_DIV);
            if (w_accept) begin
                r_op_a    <= req_a;
                r_op_b    <= req_b;
                r_opc_out <= opc_is_legal(req_opc) ? req_opc : OPC_IDLE;
            end else if (w_handshake) begin
                r_opc_out <= OPC_IDLE;
            end
            if (w_capture) begin
                r_rsp_data <= res_data;
                r_rsp_aeb  <= (r_opc_out == OPC_CMP) && res_aeb;
                r_rsp_agb  <= (r_opc_out == OPC_CMP) && res_agb;
                r_rsp_alb  <= (r_opc_out == OPC_CMP) && res_alb;
                r_rsp_err  <= 1'b0;
            end else if (w_err_rsp) begin
                r_rsp_data <= '0;
                r_rsp_aeb  <= 1'b0;
                r_rsp_agb  <= 1'b0;
                r_rsp_alb  <= 1'b0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign opc_out   = r_opc_out;
    assign div_start = r_div_start;
    assign rsp_data  = r_rsp_data;
    assign rsp_aeb   = r_rsp_aeb;
    assign rsp_agb   = r_rsp_agb;
    assign rsp_alb   = r_rsp_alb;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule
